// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter: one packed BCD word in, one binary result out,
// one digit per cycle MSD first. Optional signed output under BCD_TO_BIN_SIGN_EN.
module bcd_to_bin_seq #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4*DIGITS-1:0] in_bcd,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_err,
`ifdef BCD_TO_BIN_SIGN_EN
  input  logic                in_neg,
  output logic [BIN_W:0]      out_bin
`else
  output logic [BIN_W-1:0]    out_bin
`endif
);

`ifdef BCD_TO_BIN_SIGN_EN
  localparam int OUT_W = BIN_W + 1;
`else
  localparam int OUT_W = BIN_W;
`endif
  localparam int CNT_W = $clog2(DIGITS + 1);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t              state_reg;
  logic [4*DIGITS-1:0] shift_reg;
  logic [BIN_W-1:0]    acc_reg;
  logic [BIN_W-1:0]    acc_next;
  logic [CNT_W-1:0]    cnt_reg;
  logic                err_reg;
  logic                err_next;
  logic [3:0]          digit;
  logic [OUT_W-1:0]    result_next;
`ifdef BCD_TO_BIN_SIGN_EN
  logic                neg_reg;
  logic [OUT_W-1:0]    mag;
`endif

  // Current digit is always the top nibble; the word shifts left after each step.
  assign digit    = shift_reg[4*DIGITS-1 -: 4];
  // acc*10 as (acc<<3)+(acc<<1); carries past BIN_W bits are dropped on purpose.
  assign acc_next = (acc_reg << 3) + (acc_reg << 1) + BIN_W'(digit);
  assign err_next = err_reg | (digit > 4'd9);

`ifdef BCD_TO_BIN_SIGN_EN
  assign mag         = {1'b0, acc_next};
  assign result_next = neg_reg ? (~mag + 1'b1) : mag;
`else
  assign result_next = acc_next;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_bin   <= '0;
      out_err   <= 1'b0;
      acc_reg   <= '0;
      cnt_reg   <= '0;
      err_reg   <= 1'b0;
      shift_reg <= '0;
`ifdef BCD_TO_BIN_SIGN_EN
      neg_reg   <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid && in_ready) begin
            shift_reg <= in_bcd;
            acc_reg   <= '0;
            err_reg   <= 1'b0;
            cnt_reg   <= '0;
            in_ready  <= 1'b0;
            state_reg <= CONV;
`ifdef BCD_TO_BIN_SIGN_EN
            neg_reg   <= in_neg;
`endif
          end
        end
        CONV: begin
          shift_reg <= shift_reg << 4;
          acc_reg   <= acc_next;
          err_reg   <= err_next;
          cnt_reg   <= cnt_reg + 1'b1;
          if (cnt_reg == CNT_W'(DIGITS - 1)) begin
            out_bin   <= result_next;
            out_err   <= err_next;
            out_valid <= 1'b1;
            state_reg <= DONE;
          end
        end
        DONE: begin
          // in_ready rises on the handshake edge, so the next accept is one edge later.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Directed bench for bcd_to_bin_seq: vector table plus hand-written stall, back-to-back
// and reset-abort sequences; sign vectors only when BCD_TO_BIN_SIGN_EN is defined.
module tb_bcd_to_bin_seq;
  localparam int DIGITS = 4;
  localparam int BIN_W  = 14;
`ifdef BCD_TO_BIN_SIGN_EN
  localparam int OUT_W = BIN_W + 1;
`else
  localparam int OUT_W = BIN_W;
`endif

  logic                clk = 1'b0;
  logic                reset;
  logic                in_valid;
  logic                in_ready;
  logic [4*DIGITS-1:0] in_bcd;
  logic                out_valid;
  logic                out_ready;
  logic                out_err;
  logic [OUT_W-1:0]    out_bin;
`ifdef BCD_TO_BIN_SIGN_EN
  logic                in_neg;
`endif

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  bcd_to_bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bcd    (in_bcd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_err   (out_err),
`ifdef BCD_TO_BIN_SIGN_EN
    .in_neg    (in_neg),
`endif
    .out_bin   (out_bin)
  );

  typedef struct {
    logic [15:0] bcd;
    logic        neg;
    logic [31:0] bin;
    logic        err;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_neg(input logic neg);
`ifdef BCD_TO_BIN_SIGN_EN
    in_neg = neg;
`else
    if (neg) $display("note: sign request ignored in unsigned build");
`endif
  endtask

  task automatic run_word(input logic [15:0] bcd, input logic neg,
                          input logic [31:0] exp_bin, input logic exp_err);
    int n;
    out_ready = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin tick(); n++; end
    check("ready_before_accept", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_bcd   = bcd;
    set_neg(neg);
    tick();
    in_valid = 1'b0;
    check("busy_after_accept", {31'd0, in_ready}, 32'd0);
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    check("latency", n, DIGITS);
    check("out_bin", 32'(out_bin), exp_bin);
    check("out_err", {31'd0, out_err}, {31'd0, exp_err});
    $display("word %h neg %0d -> bin 0x%0h err %0d (latency %0d)", bcd, neg, out_bin, out_err, n);
    tick();
    check("valid_drop", {31'd0, out_valid}, 32'd0);
    check("ready_back", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int acc_cyc[2];
    logic [31:0] res[2];
    int acc_cnt, res_cnt, cyc, n, seen;
    logic prev_rdy, prev_vld;

    vecs[0] = '{16'h1234, 1'b0, 32'd1234, 1'b0};
    vecs[1] = '{16'h9999, 1'b0, 32'd9999, 1'b0};
    vecs[2] = '{16'h0000, 1'b0, 32'd0,    1'b0};
    vecs[3] = '{16'h12A4, 1'b0, 32'd1304, 1'b1};
    vecs[4] = '{16'hFFFF, 1'b0, 32'd281,  1'b1};  // 16665 mod 2^14
    vecs[5] = '{16'h9090, 1'b0, 32'd9090, 1'b0};
    vecs[6] = '{16'h0009, 1'b0, 32'd9,    1'b0};

    reset = 1'b1; in_valid = 1'b0; in_bcd = '0; out_ready = 1'b0;
    set_neg(1'b0);
    tick(); tick();
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_bin",   32'(out_bin),       32'd0);
    check("rst_out_err",   {31'd0, out_err},   32'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 7; i++)
      run_word(vecs[i].bcd, vecs[i].neg, vecs[i].bin, vecs[i].err);

    // Back-to-back words with in_valid held high.
    out_ready = 1'b1; in_valid = 1'b1; in_bcd = 16'h9999;
    acc_cnt = 0; res_cnt = 0; cyc = 0;
    for (int c = 0; c < 30 && res_cnt < 2; c++) begin
      prev_rdy = in_ready; prev_vld = in_valid;
      tick(); cyc++;
      if (prev_rdy && prev_vld && acc_cnt < 2) begin
        acc_cyc[acc_cnt] = cyc; acc_cnt++;
        in_bcd = 16'h0000;
        if (acc_cnt == 2) in_valid = 1'b0;
      end
      if (out_valid && res_cnt < 2) begin res[res_cnt] = 32'(out_bin); res_cnt++; end
    end
    in_valid = 1'b0;
    check("b2b_accepts", acc_cnt, 2);
    check("b2b_results", res_cnt, 2);
    if (acc_cnt == 2) check("b2b_period", acc_cyc[1] - acc_cyc[0], 6);
    if (res_cnt == 2) begin
      check("b2b_res0", res[0], 32'd9999);
      check("b2b_res1", res[1], 32'd0);
    end
    $display("back-to-back: accepts %0d results %0d", acc_cnt, res_cnt);
    tick();

    // Output stall: hold out_ready low in DONE while poking in_valid.
    out_ready = 1'b0; in_valid = 1'b1; in_bcd = 16'h4321;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    for (int c = 0; c < 5; c++) begin
      in_valid = (c % 2 == 0); in_bcd = 16'h1111;
      tick();
      check("stall_valid", {31'd0, out_valid}, 32'd1);
      check("stall_bin",   32'(out_bin),       32'd4321);
      check("stall_err",   {31'd0, out_err},   32'd0);
      check("stall_ready", {31'd0, in_ready},  32'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    check("stall_release_valid", {31'd0, out_valid}, 32'd0);
    check("stall_release_ready", {31'd0, in_ready},  32'd1);
    seen = 0;
    for (int c = 0; c < 8; c++) begin tick(); if (out_valid) seen++; end
    check("stall_no_ghost", seen, 0);
    $display("stall: held 5 cycles at 4321");

    // Reset during the second CONV cycle aborts the word.
    in_valid = 1'b1; in_bcd = 16'h5678;
    tick();
    in_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_ready", {31'd0, in_ready},  32'd1);
    check("abort_valid", {31'd0, out_valid}, 32'd0);
    check("abort_bin",   32'(out_bin),       32'd0);
    seen = 0;
    for (int c = 0; c < 8; c++) begin tick(); if (out_valid) seen++; end
    check("abort_no_result", seen, 0);
    $display("abort: 5678 discarded");

    // Reset coinciding with an output handshake in DONE wins.
    out_ready = 1'b0; in_valid = 1'b1; in_bcd = 16'h0777;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    check("done_pre_bin", 32'(out_bin), 32'd777);
    reset = 1'b1; out_ready = 1'b1;
    tick();
    reset = 1'b0;
    check("done_rst_valid", {31'd0, out_valid}, 32'd0);
    check("done_rst_bin",   32'(out_bin),       32'd0);
    check("done_rst_ready", {31'd0, in_ready},  32'd1);
    $display("reset in DONE: outputs cleared");

`ifdef BCD_TO_BIN_SIGN_EN
    run_word(16'h0042, 1'b1, 32'h7FD6, 1'b0);
    run_word(16'h0000, 1'b1, 32'd0,    1'b0);
    run_word(16'h9999, 1'b1, 32'h58F1, 1'b0);
    run_word(16'h0042, 1'b0, 32'd42,   1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
